// File: rtl/mode_sequencer_pkg.sv
// mode_sequencer_pkg
//   State codes, group codes and decode helpers shared by the mode sequencer
//   and the display mux.
//   State code layout: {1'b0, group[1:0], sub[2:0]}.
//   Groups: TIME=00, DATE=01, STW=10, ALM=11.
//   Optional feature macro used by the design: MODE_SEQ_AUTO_RETURN_EN.
package mode_sequencer_pkg;

  localparam logic [1:0] GRP_TIME = 2'b00;
  localparam logic [1:0] GRP_DATE = 2'b01;
  localparam logic [1:0] GRP_STW  = 2'b10;
  localparam logic [1:0] GRP_ALM  = 2'b11;

  // One-hot field selects: [2]=hour/year, [1]=min/month, [0]=sec/date.
  localparam logic [2:0] FLD_NONE = 3'b000;
  localparam logic [2:0] FLD_HI   = 3'b100;
  localparam logic [2:0] FLD_MID  = 3'b010;
  localparam logic [2:0] FLD_LO   = 3'b001;

  typedef enum logic [5:0] {
    TIME_DISP     = {1'b0, GRP_TIME, 3'd0},
    TIME_DISP1    = {1'b0, GRP_TIME, 3'd1},
    TIME_SETHOUR  = {1'b0, GRP_TIME, 3'd2},
    TIME_SETMIN   = {1'b0, GRP_TIME, 3'd3},
    TIME_SETSEC   = {1'b0, GRP_TIME, 3'd4},
    DATE_DISP     = {1'b0, GRP_DATE, 3'd0},
    DATE_DISP1    = {1'b0, GRP_DATE, 3'd1},
    DATE_SETYEAR  = {1'b0, GRP_DATE, 3'd2},
    DATE_SETMONTH = {1'b0, GRP_DATE, 3'd3},
    DATE_SETDATE  = {1'b0, GRP_DATE, 3'd4},
    STW_DISP      = {1'b0, GRP_STW,  3'd0},
    STW_COUNT     = {1'b0, GRP_STW,  3'd1},
    STW_LAP_COUNT = {1'b0, GRP_STW,  3'd2},
    ALM_DISP      = {1'b0, GRP_ALM,  3'd0},
    ALM_SETHOUR   = {1'b0, GRP_ALM,  3'd2},
    ALM_SETMIN    = {1'b0, GRP_ALM,  3'd3}
  } state_t;

  function automatic logic [2:0] field_sel(input state_t s);
    case (s)
      TIME_SETHOUR, DATE_SETYEAR, ALM_SETHOUR: field_sel = FLD_HI;
      TIME_SETMIN, DATE_SETMONTH, ALM_SETMIN:  field_sel = FLD_MID;
      TIME_SETSEC, DATE_SETDATE:               field_sel = FLD_LO;
      default:                                 field_sel = FLD_NONE;
    endcase
  endfunction

  function automatic logic is_set_state(input state_t s);
    is_set_state = (field_sel(s) != FLD_NONE);
  endfunction

  function automatic logic is_stw_running(input state_t s);
    is_stw_running = (s == STW_COUNT) || (s == STW_LAP_COUNT);
  endfunction

  // LED order is TIME, DATE, STW, ALM from bit 3 down to bit 0.
  function automatic logic [3:0] group_onehot(input state_t s);
    group_onehot = 4'b1000 >> s[4:3];
  endfunction

  // States that fall back to TIME_DISP after the idle timeout.
  function automatic logic idle_eligible(input state_t s);
    idle_eligible = is_set_state(s) || (s == TIME_DISP1) || (s == DATE_DISP1) ||
                    (s == DATE_DISP) || (s == ALM_DISP);
  endfunction

endpackage

// File: rtl/mode_sequencer_btn_pulse.sv
// btn_pulse
//   Two-flop synchronizer followed by a rising-edge detector. Produces a
//   registered one-cycle pulse per button press, however long it is held.
//   A level meeting setup before edge 0 gives o_pulse high after edge 2.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   i_btn   in  raw debounced button level (asynchronous to clk)
//   o_pulse out registered one-cycle press pulse
module btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer
//   Button-driven controller sequencing the clock datapath (time/date
//   counters, stopwatch, alarm, setting registers). Three button presses
//   drive a 16-state machine; every output is registered.
//   Optional feature: define MODE_SEQ_AUTO_RETURN_EN to build the idle
//   counter that returns to TIME_DISP after TIMEOUT_S ticks of inactivity.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tick                    1 Hz one-cycle strobe (idle timeout only)
//   mode, switch,
//   display_mode            debounced button levels, asynchronous
//   state[5:0]              {1'b0, group, sub}
//   set_enable              increment strobe for the selected field
//   set_hour_min_sec[2:0]   one-hot field select, zero outside set states
//   reg_load_enable         copy live values into setting registers
//   data_load_enable        commit edit / stopwatch lap strobe
//   stopwatch_count_enable  stopwatch running level
//   alarm_enable            alarm armed level
//   state_led[5:0]          {group one-hot, in-set, stopwatch running}
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       mode,
  input  logic       switch,
  input  logic       display_mode,
  output logic [5:0] state,
  output logic       set_enable,
  output logic [2:0] set_hour_min_sec,
  output logic       reg_load_enable,
  output logic       data_load_enable,
  output logic       stopwatch_count_enable,
  output logic       alarm_enable,
  output logic [5:0] state_led
);

  logic w_p_mode, w_p_sw, w_p_dm;
  logic w_mode, w_sw, w_dm, w_any_press;

  btn_pulse u_btn_mode (.clk(clk), .rst_n(rst_n), .i_btn(mode),         .o_pulse(w_p_mode));
  btn_pulse u_btn_sw   (.clk(clk), .rst_n(rst_n), .i_btn(switch),       .o_pulse(w_p_sw));
  btn_pulse u_btn_dm   (.clk(clk), .rst_n(rst_n), .i_btn(display_mode), .o_pulse(w_p_dm));

  // Priority mode > switch > display_mode; a losing press is dropped even
  // when the winner is ignored in the current state.
  assign w_mode      = w_p_mode;
  assign w_sw        = w_p_sw & ~w_p_mode;
  assign w_dm        = w_p_dm & ~w_p_mode & ~w_p_sw;
  assign w_any_press = w_p_mode | w_p_sw | w_p_dm;

  state_t     r_state;
  logic       r_set_en, r_reg_ld, r_data_ld, r_swen, r_alarm;
  logic [2:0] r_field;
  logic [5:0] r_led;

  state_t     w_next;
  logic       w_set_en, w_reg_ld, w_data_ld, w_alarm_next, w_swen_next;
  logic       w_timeout;

`ifdef MODE_SEQ_AUTO_RETURN_EN
  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  logic [IDLE_W-1:0] r_idle;

  assign w_timeout = (r_idle == IDLE_W'(TIMEOUT_S)) && idle_eligible(r_state);

  // Saturates at TIMEOUT_S; the resulting state change clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (w_any_press || (w_next != r_state)) begin
      r_idle <= '0;
    end else if (tick && idle_eligible(r_state) && (r_idle != IDLE_W'(TIMEOUT_S))) begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = tick ^ w_any_press ^ (TIMEOUT_S != 0);
`endif

  always_comb begin
    w_next       = r_state;
    w_set_en     = 1'b0;
    w_reg_ld     = 1'b0;
    w_data_ld    = 1'b0;
    w_alarm_next = r_alarm;
    case (r_state)
      TIME_DISP: begin
        if (w_mode)    w_next = DATE_DISP;
        else if (w_sw) begin w_reg_ld = 1'b1; w_next = TIME_SETHOUR; end
        else if (w_dm) w_next = TIME_DISP1;
      end
      TIME_DISP1: begin
        if (w_mode)    w_next = DATE_DISP;
        else if (w_dm) w_next = TIME_DISP;
      end
      TIME_SETHOUR:  if (w_mode) w_next = TIME_SETMIN;
      TIME_SETMIN:   if (w_mode) w_next = TIME_SETSEC;
      TIME_SETSEC:   if (w_mode) begin w_data_ld = 1'b1; w_next = TIME_DISP; end
      DATE_DISP: begin
        if (w_mode)    w_next = STW_DISP;
        else if (w_sw) begin w_reg_ld = 1'b1; w_next = DATE_SETYEAR; end
        else if (w_dm) w_next = DATE_DISP1;
      end
      DATE_DISP1: begin
        if (w_mode)    w_next = STW_DISP;
        else if (w_dm) w_next = DATE_DISP;
      end
      DATE_SETYEAR:  if (w_mode) w_next = DATE_SETMONTH;
      DATE_SETMONTH: if (w_mode) w_next = DATE_SETDATE;
      DATE_SETDATE:  if (w_mode) begin w_data_ld = 1'b1; w_next = DATE_DISP; end
      STW_DISP: begin
        if (w_mode)    w_next = ALM_DISP;
        else if (w_sw) w_next = STW_COUNT;
      end
      // mode is ignored while the stopwatch runs.
      STW_COUNT: begin
        if (w_sw)      w_next = STW_DISP;
        else if (w_dm) begin w_data_ld = 1'b1; w_next = STW_LAP_COUNT; end
      end
      STW_LAP_COUNT: begin
        if (w_sw)      w_next = STW_DISP;
        else if (w_dm) w_next = STW_COUNT;
      end
      ALM_DISP: begin
        if (w_mode)    w_next = TIME_DISP;
        else if (w_sw) begin w_reg_ld = 1'b1; w_next = ALM_SETHOUR; end
        else if (w_dm) w_alarm_next = ~r_alarm;
      end
      ALM_SETHOUR:   if (w_mode) w_next = ALM_SETMIN;
      ALM_SETMIN:    if (w_mode) begin w_data_ld = 1'b1; w_next = ALM_DISP; end
      default:       w_next = TIME_DISP;
    endcase

    // switch in any set state bumps the selected field without moving.
    if (is_set_state(r_state) && w_sw) w_set_en = 1'b1;

    // Auto-return discards the edit: no commit strobe.
    if (w_timeout) begin
      w_next    = TIME_DISP;
      w_set_en  = 1'b0;
      w_reg_ld  = 1'b0;
      w_data_ld = 1'b0;
    end
  end

  assign w_swen_next = is_stw_running(w_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TIME_DISP;
      r_set_en  <= 1'b0;
      r_reg_ld  <= 1'b0;
      r_data_ld <= 1'b0;
      r_swen    <= 1'b0;
      r_alarm   <= 1'b0;
      r_field   <= FLD_NONE;
      r_led     <= 6'b100000;
    end else begin
      r_state   <= w_next;
      r_set_en  <= w_set_en;
      r_reg_ld  <= w_reg_ld;
      r_data_ld <= w_data_ld;
      r_swen    <= w_swen_next;
      r_alarm   <= w_alarm_next;
      r_field   <= field_sel(w_next);
      r_led     <= {group_onehot(w_next), is_set_state(w_next), w_swen_next};
    end
  end

  assign state                  = r_state;
  assign set_enable             = r_set_en;
  assign set_hour_min_sec       = r_field;
  assign reg_load_enable        = r_reg_ld;
  assign data_load_enable       = r_data_ld;
  assign stopwatch_count_enable = r_swen;
  assign alarm_enable           = r_alarm;
  assign state_led              = r_led;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer
//   Directed-stimulus bench for mode_sequencer. A behavioural model tracks
//   the clock UI as (group, field being edited, alternate display, stopwatch
//   running/lap, alarm) and is compared against every output on each cycle;
//   literal expectations pin the model at key points.
//   Honours MODE_SEQ_AUTO_RETURN_EN in the same way as the design.
module tb_mode_sequencer;

  localparam int TIMEOUT_S = 30;

  localparam logic [5:0] S_TIME_DISP  = 6'b000000;
  localparam logic [5:0] S_TIME_DISP1 = 6'b000001;
  localparam logic [5:0] S_TIME_SETH  = 6'b000010;
  localparam logic [5:0] S_DATE_DISP  = 6'b001000;
  localparam logic [5:0] S_DATE_SETM  = 6'b001011;
  localparam logic [5:0] S_STW_DISP   = 6'b010000;
  localparam logic [5:0] S_STW_COUNT  = 6'b010001;
  localparam logic [5:0] S_STW_LAP    = 6'b010010;
  localparam logic [5:0] S_ALM_DISP   = 6'b011000;
  localparam logic [5:0] S_ALM_SETMIN = 6'b011011;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_i = 1'b0;
  logic mode_i = 1'b0, sw_i = 1'b0, dm_i = 1'b0;

  logic [5:0] state, state_led;
  logic       set_enable, reg_load_enable, data_load_enable;
  logic       stopwatch_count_enable, alarm_enable;
  logic [2:0] set_hour_min_sec;

  mode_sequencer #(.TIMEOUT_S(TIMEOUT_S)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick_i),
    .mode(mode_i), .switch(sw_i), .display_mode(dm_i),
    .state(state), .set_enable(set_enable), .set_hour_min_sec(set_hour_min_sec),
    .reg_load_enable(reg_load_enable), .data_load_enable(data_load_enable),
    .stopwatch_count_enable(stopwatch_count_enable), .alarm_enable(alarm_enable),
    .state_led(state_led)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int   m_grp;        // 0 TIME, 1 DATE, 2 STW, 3 ALM
  int   m_field;      // -1 when not editing, else 0=hi,1=mid,2=lo
  bit   m_disp1, m_run, m_lap, m_alarm;
  bit   e_se, e_rl, e_dl;
  int   m_idle;
  int   cyc;
  bit   prev_m, prev_s, prev_d;
  bit   pend_m[8], pend_s[8], pend_d[8];

  function automatic int nfields();
    return (m_grp == 3) ? 2 : 3;
  endfunction

  function automatic logic [5:0] m_code();
    int sub;
    if (m_field >= 0)      sub = 2 + m_field;
    else if (m_disp1)      sub = 1;
    else if (m_grp == 2)   sub = m_run ? (m_lap ? 2 : 1) : 0;
    else                   sub = 0;
    return {1'b0, 2'(m_grp), 3'(sub)};
  endfunction

  function automatic logic [19:0] m_outputs();
    logic [2:0] fld;
    logic [3:0] g1h;
    fld = (m_field >= 0) ? (3'b100 >> m_field) : 3'b000;
    g1h = 4'b1000 >> m_grp;
    return {m_code(), e_se, fld, e_rl, e_dl, m_run, m_alarm,
            g1h, (m_field >= 0), m_run};
  endfunction

  function automatic bit m_eligible();
    return (m_field >= 0) || m_disp1 || (m_grp == 1) || (m_grp == 3);
  endfunction

  task automatic m_reset();
    m_grp = 0; m_field = -1; m_disp1 = 0; m_run = 0; m_lap = 0; m_alarm = 0;
    e_se = 0; e_rl = 0; e_dl = 0; m_idle = 0;
    prev_m = 0; prev_s = 0; prev_d = 0;
    for (int i = 0; i < 8; i++) begin pend_m[i] = 0; pend_s[i] = 0; pend_d[i] = 0; end
  endtask

  task automatic m_apply(input bit pm, input bit ps, input bit pd);
    if (pm) begin
      if (m_field >= 0) begin
        if (m_field == nfields() - 1) begin e_dl = 1; m_field = -1; end
        else m_field++;
      end else if (!(m_grp == 2 && m_run)) begin
        m_grp = (m_grp + 1) % 4; m_disp1 = 0;
      end
    end else if (ps) begin
      if (m_field >= 0)    e_se = 1;
      else if (m_disp1)    ;
      else if (m_grp == 2) begin m_run = !m_run; m_lap = 0; end
      else begin e_rl = 1; m_field = 0; end
    end else if (pd) begin
      if (m_field < 0 && m_grp < 2)           m_disp1 = !m_disp1;
      else if (m_grp == 2 && m_run) begin
        if (!m_lap) begin m_lap = 1; e_dl = 1; end
        else m_lap = 0;
      end else if (m_grp == 3 && m_field < 0) m_alarm = !m_alarm;
    end
  endtask

  // A button rising edge seen at edge k takes effect at edge k+3.
  initial begin
    bit pm, ps, pd, elig, timed;
    logic [5:0] old;
    int slot;
    m_reset();
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        slot = cyc % 8;
        pm = pend_m[slot]; ps = pend_s[slot]; pd = pend_d[slot];
        pend_m[slot] = 0; pend_s[slot] = 0; pend_d[slot] = 0;
        e_se = 0; e_rl = 0; e_dl = 0;
        old = m_code();
        elig = m_eligible();
        timed = 0;
`ifdef MODE_SEQ_AUTO_RETURN_EN
        if (elig && m_idle >= TIMEOUT_S) begin
          m_grp = 0; m_field = -1; m_disp1 = 0; timed = 1;
        end
`endif
        if (!timed) m_apply(pm, ps, pd);
`ifdef MODE_SEQ_AUTO_RETURN_EN
        if (pm || ps || pd || m_code() != old) m_idle = 0;
        else if (tick_i && elig && m_idle < TIMEOUT_S) m_idle++;
`endif
        slot = (cyc + 3) % 8;
        pend_m[slot] = mode_i && !prev_m;
        pend_s[slot] = sw_i   && !prev_s;
        pend_d[slot] = dm_i   && !prev_d;
        prev_m = mode_i; prev_s = sw_i; prev_d = dm_i;
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare and strobe counters ----------------
  bit cmp_on = 0;
  int n_se = 0, n_rl = 0, n_dl = 0;

  initial forever begin
    @(negedge clk);
    if (cmp_on)
      chk("cycle outputs",
          {state, set_enable, set_hour_min_sec, reg_load_enable, data_load_enable,
           stopwatch_count_enable, alarm_enable, state_led},
          m_outputs());
    if (set_enable)       n_se++;
    if (reg_load_enable)  n_rl++;
    if (data_load_enable) n_dl++;
  end

  bit tick_en = 0;
  int tick_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (tick_en) begin tick_cnt++; tick_i = (tick_cnt % 10 == 0); end
    else tick_i = 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic m, input logic s, input logic d, input int hold);
    @(negedge clk);
    mode_i = m; sw_i = s; dm_i = d;
    repeat (hold) @(negedge clk);
    mode_i = 0; sw_i = 0; dm_i = 0;
    repeat (6) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    logic [5:0] exp_st [4];
    logic [3:0] exp_led[4];
    exp_st[0] = S_DATE_DISP;  exp_led[0] = 4'b0100;
    exp_st[1] = S_STW_DISP;   exp_led[1] = 4'b0010;
    exp_st[2] = S_ALM_DISP;   exp_led[2] = 4'b0001;
    exp_st[3] = S_TIME_DISP;  exp_led[3] = 4'b1000;

    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    cmp_on = 1;
    chk("reset state", state, S_TIME_DISP);
    chk("reset led", state_led, 6'b100000);
    chk("reset strobes", {set_enable, reg_load_enable, data_load_enable,
                          stopwatch_count_enable, alarm_enable, set_hour_min_sec}, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);

    // Group cycling
    for (int i = 0; i < 4; i++) begin
      press(1, 0, 0, 2);
      chk("mode cycle state", state, exp_st[i]);
      chk("mode cycle led", state_led[5:2], exp_led[i]);
    end

    // Time set sequence
    press(0, 1, 0, 1);
    chk("enter time set", state, S_TIME_SETH);
    chk("hour field", set_hour_min_sec, 3'b100);
    chk("reg load count", n_rl, 1);
    for (int i = 0; i < 3; i++) press(0, 1, 0, 3);
    chk("set pulses", n_se, 3);
    press(1, 0, 0, 1);
    chk("min field", set_hour_min_sec, 3'b010);
    press(1, 0, 0, 1);
    chk("sec field", set_hour_min_sec, 3'b001);
    press(1, 0, 0, 1);
    chk("commit load", n_dl, 1);
    chk("back to time disp", state, S_TIME_DISP);

    // Simultaneous mode+switch: mode wins
    press(1, 1, 0, 2);
    chk("simul state", state, S_DATE_DISP);
    chk("simul no reg load", n_rl, 1);

    // Held switch in a set state: one set pulse only
    press(0, 1, 0, 1);
    base = n_se;
    press(0, 1, 0, 1000);
    chk("held switch one pulse", n_se - base, 1);
    for (int i = 0; i < 3; i++) press(1, 0, 0, 1);
    chk("date commit", state, S_DATE_DISP);
    press(1, 0, 0, 1);

    // Stopwatch
    chk("at stw disp", state, S_STW_DISP);
    press(0, 1, 0, 1);
    chk("stw count", state, S_STW_COUNT);
    chk("stw enable on", stopwatch_count_enable, 1);
    chk("stw led0", state_led[0], 1);
    base = n_dl;
    press(0, 0, 1, 1);
    chk("stw lap", state, S_STW_LAP);
    chk("lap load", n_dl - base, 1);
    press(1, 0, 0, 1);
    chk("mode ignored in lap", state, S_STW_LAP);
    press(0, 1, 0, 1);
    chk("stw stop", state, S_STW_DISP);
    chk("stw enable off", stopwatch_count_enable, 0);

    // Alarm arm, then idle in ALM_SETMIN
    press(1, 0, 0, 1);
    press(0, 0, 1, 1);
    chk("alarm armed", alarm_enable, 1);
    press(0, 1, 0, 1);
    press(1, 0, 0, 1);
    chk("alm setmin", state, S_ALM_SETMIN);
    base = n_dl;
    tick_en = 1;
    repeat (1005) @(negedge clk);
    tick_en = 0;
    repeat (2) @(negedge clk);
`ifdef MODE_SEQ_AUTO_RETURN_EN
    chk("timeout returns", state, S_TIME_DISP);
    chk("timeout no commit", n_dl - base, 0);
`else
    chk("no timeout", state, S_ALM_SETMIN);
    press(1, 0, 0, 1);
    press(1, 0, 0, 1);
`endif
    chk("at time disp", state, S_TIME_DISP);
    chk("alarm kept", alarm_enable, 1);

    // DISP1 toggle and ignored switch
    press(0, 0, 1, 1);
    chk("time disp1", state, S_TIME_DISP1);
    press(0, 1, 0, 1);
    chk("switch ignored disp1", state, S_TIME_DISP1);
    press(0, 0, 1, 1);
    chk("back from disp1", state, S_TIME_DISP);

    // Reset mid-edit
    press(1, 0, 0, 1);
    press(0, 1, 0, 1);
    press(1, 0, 0, 1);
    chk("date setmonth", state, S_DATE_SETM);
    base = n_dl;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midreset state", state, S_TIME_DISP);
    chk("midreset alarm", alarm_enable, 0);
    chk("midreset field", set_hour_min_sec, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    chk("no strobe after reset", n_dl - base, 0);
    chk("idle after reset", state, S_TIME_DISP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
